// File: rtl/fibo_bin2bcd_pkg.sv
// Shared types and defaults for the fibo_bin2bcd shift-and-add-3 converter.
package fibo_bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    OP,
    DONE
  } state_t;

  localparam int unsigned DEF_BIN_W  = 21;
  localparam int unsigned DEF_DIGITS = 7;

  // Width of a counter that must hold the value w.
  function automatic int unsigned cnt_w(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/fibo_bin2bcd_dd.sv
// Per-digit double-dabble adjust: add 3 when the digit is 5 or more.
module bcd_dd_cell (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  always_comb begin
    dout = din;
    if (din >= 4'd5) dout = din + 4'd3;
  end

endmodule

// File: rtl/fibo_bin2bcd.sv
// Sequential binary-to-BCD converter, one input bit per clock, with the
// same start/ready/done_tick handshake as the upstream fibo stage.
module fibo_bin2bcd
  import fibo_bin2bcd_pkg::*;
#(
  parameter int unsigned BIN_W  = DEF_BIN_W,
  parameter int unsigned DIGITS = DEF_DIGITS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [BIN_W-1:0]            bin,
  output logic                        ready,
  output logic                        done_tick,
  output logic [4*DIGITS-1:0]         bcd,
  output logic [cnt_w(DIGITS)-1:0]    ndigits
);

  localparam int unsigned NW  = cnt_w(BIN_W);
  localparam int unsigned NDW = cnt_w(DIGITS);

  state_t              state, state_nxt;
  logic [BIN_W-1:0]    sh;
  logic [4*DIGITS-1:0] dig;
  logic [4*DIGITS-1:0] adj;
  logic [NW-1:0]       n;
  logic [NDW-1:0]      nd_calc;

  for (genvar i = 0; i < DIGITS; i++) begin : g_cell
    bcd_dd_cell u_cell (
      .din  (dig[4*i +: 4]),
      .dout (adj[4*i +: 4])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    unique case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_nxt = OP;
      end
      OP:      if (n == NW'(1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Highest nonzero digit wins; an all-zero result still reports one digit.
  always_comb begin
    nd_calc = NDW'(1);
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (dig[4*i +: 4] != 4'd0) nd_calc = NDW'(i + 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh        <= '0;
      dig       <= '0;
      n         <= '0;
      bcd       <= '0;
      ndigits   <= NDW'(1);
      done_tick <= 1'b0;
    end else begin
      done_tick <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            sh  <= bin;
            dig <= '0;
            n   <= NW'(BIN_W);
          end
        end
        OP: begin
          dig <= {adj[4*DIGITS-2:0], sh[BIN_W-1]};
          sh  <= {sh[BIN_W-2:0], 1'b0};
          n   <= n - NW'(1);
        end
        DONE: begin
          bcd       <= dig;
          ndigits   <= nd_calc;
          done_tick <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fibo_bin2bcd.sv
// Directed self-checking bench for fibo_bin2bcd.
module tb_fibo_bin2bcd;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [20:0] bin = '0;
  logic        ready;
  logic        done_tick;
  logic [27:0] bcd;
  logic [2:0]  ndigits;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fibo_bin2bcd #(.BIN_W(21), .DIGITS(7)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bin       (bin),
    .ready     (ready),
    .done_tick (done_tick),
    .bcd       (bcd),
    .ndigits   (ndigits)
  );

  function automatic logic [27:0] dec_bcd(input int unsigned v);
    logic [27:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int d = 0; d < 7; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [2:0] dec_nd(input int unsigned v);
    int unsigned x;
    int nd;
    x = v;
    nd = 0;
    while (x != 0) begin
      nd++;
      x = x / 10;
    end
    if (nd == 0) nd = 1;
    return 3'(nd);
  endfunction

  // Pulse start with v, return result and clocks from accepting edge to done_tick (-1 on timeout).
  task automatic convert(input logic [20:0] v, output logic [27:0] got_bcd,
                         output logic [2:0] got_nd, output int lat);
    @(negedge clk);
    bin   = v;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (done_tick) begin
        lat = c;
        break;
      end
    end
    got_bcd = bcd;
    got_nd  = ndigits;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (ready !== 1'b1 || done_tick !== 1'b0 || bcd !== 28'h0 || ndigits !== 3'd1) begin
      bad++;
      $display("FAIL reset: ready=%b done=%b bcd=%h nd=%0d, want 1 0 0000000 1",
               ready, done_tick, bcd, ndigits);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_zero;
    int lat;
    @(negedge clk);
    bin   = '0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    total++;
    if (ready !== 1'b0) begin
      bad++;
      $display("FAIL ready_drop: ready=%b want 0", ready);
    end
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (done_tick) begin
        lat = c;
        break;
      end
    end
    total++;
    if (lat != 22) begin
      bad++;
      $display("FAIL zero_latency: got=%0d want 22", lat);
    end
    total++;
    if (bcd !== 28'h0000000 || ndigits !== 3'd1) begin
      bad++;
      $display("FAIL zero_value: bcd=%h nd=%0d want 0000000 1", bcd, ndigits);
    end
    @(posedge clk);
    #1;
    total++;
    if (ready !== 1'b1 || done_tick !== 1'b0 || bcd !== 28'h0) begin
      bad++;
      $display("FAIL after_done: ready=%b done=%b bcd=%h want 1 0 0000000", ready, done_tick, bcd);
    end
  endtask

  task automatic test_values;
    logic [20:0] vin [4]  = '{21'd10946, 21'd1346269, 21'd2097151, 21'd9};
    logic [27:0] vexp [4] = '{28'h0010946, 28'h1346269, 28'h2097151, 28'h0000009};
    logic [2:0]  nexp [4] = '{3'd5, 3'd7, 3'd7, 3'd1};
    logic [27:0] gb;
    logic [2:0]  gn;
    int lat;
    for (int k = 0; k < 4; k++) begin
      convert(vin[k], gb, gn, lat);
      total++;
      if (lat != 22 || gb !== vexp[k] || gn !== nexp[k]) begin
        bad++;
        $display("FAIL value_%0d: lat=%0d bcd=%h nd=%0d want 22 %h %0d",
                 vin[k], lat, gb, gn, vexp[k], nexp[k]);
      end
    end
  endtask

  task automatic test_fib_sweep;
    int unsigned f0, f1, f2;
    logic [27:0] gb;
    logic [2:0]  gn;
    int lat;
    f0 = 0;
    f1 = 1;
    for (int i = 0; i <= 31; i++) begin
      convert(21'(f0), gb, gn, lat);
      total++;
      if (lat != 22 || gb !== dec_bcd(f0) || gn !== dec_nd(f0)) begin
        bad++;
        $display("FAIL fib_%0d: lat=%0d bcd=%h nd=%0d want 22 %h %0d",
                 i, lat, gb, gn, dec_bcd(f0), dec_nd(f0));
      end
      if (i == 31) begin
        total++;
        if (gb !== 28'h1346269) begin
          bad++;
          $display("FAIL fib_31_const: bcd=%h want 1346269", gb);
        end
      end
      f2 = f0 + f1;
      f0 = f1;
      f1 = f2;
    end
  endtask

  task automatic test_ignore_start;
    int ticks;
    logic [27:0] first;
    @(negedge clk);
    bin   = 21'd4242;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    ticks = 0;
    first = '1;
    for (int c = 1; c <= 45; c++) begin
      if (c == 5 || c == 10) begin
        bin   = 21'd777777;
        start = 1'b1;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done_tick) begin
        ticks++;
        if (ticks == 1) first = bcd;
      end
    end
    total++;
    if (ticks != 1) begin
      bad++;
      $display("FAIL ignore_ticks: got=%0d want 1", ticks);
    end
    total++;
    if (first !== 28'h0004242) begin
      bad++;
      $display("FAIL ignore_value: bcd=%h want 0004242", first);
    end
  endtask

  task automatic test_back_to_back;
    int t1, t2;
    logic [27:0] b1, b2;
    @(negedge clk);
    bin   = 21'd31415;
    start = 1'b1;
    @(posedge clk);
    #1 bin = 21'd27182;
    t1 = -1;
    t2 = -1;
    b1 = '1;
    b2 = '1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk);
      #1;
      if (c == 23) start = 1'b0;
      if (done_tick) begin
        if (t1 < 0) begin
          t1 = c;
          b1 = bcd;
        end else if (t2 < 0) begin
          t2 = c;
          b2 = bcd;
        end
      end
    end
    total++;
    if (t1 != 22 || t2 != 45) begin
      bad++;
      $display("FAIL b2b_timing: t1=%0d t2=%0d want 22 45", t1, t2);
    end
    total++;
    if (b1 !== 28'h0031415 || b2 !== 28'h0027182) begin
      bad++;
      $display("FAIL b2b_value: b1=%h b2=%h want 0031415 0027182", b1, b2);
    end
  endtask

  task automatic test_abort;
    int ticks;
    logic [27:0] gb;
    logic [2:0]  gn;
    int lat;
    @(negedge clk);
    bin   = 21'd500000;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    total++;
    if (ready !== 1'b1 || bcd !== 28'h0 || ndigits !== 3'd1 || done_tick !== 1'b0) begin
      bad++;
      $display("FAIL abort_state: ready=%b bcd=%h nd=%0d done=%b want 1 0000000 1 0",
               ready, bcd, ndigits, done_tick);
    end
    ticks = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1;
      if (done_tick) ticks++;
    end
    total++;
    if (ticks != 0) begin
      bad++;
      $display("FAIL abort_tick: got=%0d want 0", ticks);
    end
    convert(21'd123, gb, gn, lat);
    total++;
    if (lat != 22 || gb !== 28'h0000123 || gn !== 3'd3) begin
      bad++;
      $display("FAIL abort_restart: lat=%0d bcd=%h nd=%0d want 22 0000123 3", lat, gb, gn);
    end
  endtask

  initial begin
    test_reset;
    test_zero;
    test_values;
    test_fib_sweep;
    test_ignore_start;
    test_back_to_back;
    test_abort;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
